// File: rtl/agc_loop_ctrl_if.sv
// Control and accumulator bundle between agc_loop_ctrl (master) and one agc_core (slave).
interface agc_loop_ctrl_if;
    logic        agc_rst_o;
    logic        agc_tick_o;
    logic        agc_ce_o;
    logic [16:0] agc_scale_o;
    logic [7:0]  agc_offset_o;
    logic        agc_scale_ce_o;
    logic        agc_offset_ce_o;
    logic        agc_apply_o;
    logic [23:0] sq_accum_i;
    logic [20:0] gt_accum_i;
    logic [20:0] lt_accum_i;

    modport master (
        output agc_rst_o, agc_tick_o, agc_ce_o, agc_scale_o, agc_offset_o,
               agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
        input  sq_accum_i, gt_accum_i, lt_accum_i
    );

    modport slave (
        input  agc_rst_o, agc_tick_o, agc_ce_o, agc_scale_o, agc_offset_o,
               agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
        output sq_accum_i, gt_accum_i, lt_accum_i
    );
endinterface

// File: rtl/agc_loop_ctrl.sv
// Closed-loop rst/tick/integrate/settle/capture/compute/load/apply sequencer for one agc_core.
// Latency: start to apply is WINDOW_CLOCKS+SETTLE_CLOCKS+6 clocks; no backpressure.
// Define AGC_LOOP_CTRL_STATS_EN to build the last_sq_o capture register (tied to 0 otherwise).
module agc_loop_ctrl #(
    parameter int unsigned WINDOW_CLOCKS = 131072,
    parameter int unsigned SETTLE_CLOCKS = 6,
    parameter int unsigned SCALE_SHIFT   = 4,
    parameter logic [16:0] SCALE_INIT    = 17'h04000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             oneshot_i,
    input  logic [23:0]      target_sq_i,
    input  logic [23:0]      sq_dband_i,
    input  logic [20:0]      ofs_dband_i,
    agc_loop_ctrl_if.master  agc,
    output logic             busy_o,
    output logic             cycle_done_o,
    output logic             sat_o,
    output logic [15:0]      iter_count_o,
    output logic [23:0]      last_sq_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_TICK, S_INTEG, S_SETTLE, S_CAPTURE, S_COMPUTE, S_LOAD, S_APPLY
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [19:0]        r_cnt;
    logic               r_oneshot_mode;
    logic               r_enable_d;
    logic               r_oneshot_d;
    logic [23:0]        r_sq;
    logic [20:0]        r_gt;
    logic [20:0]        r_lt;
    logic [16:0]        r_scale;
    logic signed [7:0]  r_offset;
    logic               r_sat;
    logic [15:0]        r_iter;

    logic               w_start;
    logic               w_rise;
    logic               w_win_end;
    logic               w_settle_end;
    logic               w_rst;
    logic               w_tick;
    logic               w_ce;
    logic               w_load;
    logic               w_apply;
    logic [24:0]        w_hi_raw;
    logic [24:0]        w_lo_raw;
    logic [23:0]        w_hi;
    logic [23:0]        w_lo;
    logic [16:0]        w_shifted;
    logic [16:0]        w_step;
    logic [17:0]        w_scale_up;
    logic [16:0]        w_scale_nxt;
    logic signed [21:0] w_d;
    logic signed [21:0] w_db;
    logic signed [7:0]  w_offset_nxt;
    logic               w_sat_hit;

    assign w_start      = (r_state == S_IDLE) && (enable_i || oneshot_i);
    assign w_rise       = (enable_i && !r_enable_d) || (oneshot_i && !r_oneshot_d);
    assign w_win_end    = (r_cnt == 20'(WINDOW_CLOCKS - 1));
    assign w_settle_end = (r_cnt == 20'(SETTLE_CLOCKS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_rst       = 1'b0;
        w_tick      = 1'b0;
        w_ce        = 1'b0;
        w_load      = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_RST;
            S_RST:     begin w_rst  = 1'b1; w_state_nxt = S_TICK;  end
            S_TICK:    begin w_tick = 1'b1; w_state_nxt = S_INTEG; end
            S_INTEG: begin
                w_ce = 1'b1;
                if (w_win_end) w_state_nxt = S_SETTLE;
            end
            S_SETTLE:  if (w_settle_end) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_COMPUTE;
            S_COMPUTE: w_state_nxt = S_LOAD;
            S_LOAD:    begin w_load = 1'b1; w_state_nxt = S_APPLY; end
            S_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = (enable_i && !r_oneshot_mode) ? S_RST : S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Deadband window saturates at the 24-bit range ends instead of wrapping.
    assign w_hi_raw   = {1'b0, target_sq_i} + {1'b0, sq_dband_i};
    assign w_lo_raw   = {1'b0, target_sq_i} - {1'b0, sq_dband_i};
    assign w_hi       = w_hi_raw[24] ? 24'hFFFFFF : w_hi_raw[23:0];
    assign w_lo       = w_lo_raw[24] ? 24'h000000 : w_lo_raw[23:0];
    assign w_shifted  = r_scale >> SCALE_SHIFT;
    assign w_step     = (w_shifted == 17'd0) ? 17'd1 : w_shifted;
    assign w_scale_up = {1'b0, r_scale} + {1'b0, w_step};

    assign w_d  = signed'({1'b0, r_gt}) - signed'({1'b0, r_lt});
    assign w_db = signed'({1'b0, ofs_dband_i});

    always_comb begin
        w_scale_nxt  = r_scale;
        w_offset_nxt = r_offset;
        w_sat_hit    = 1'b0;
        if (r_sq > w_hi) begin
            if ({1'b0, r_scale} <= ({1'b0, w_step} + 18'd1)) begin
                w_scale_nxt = 17'd1;
                w_sat_hit   = 1'b1;
            end else begin
                w_scale_nxt = r_scale - w_step;
            end
        end else if (r_sq < w_lo) begin
            if (w_scale_up >= 18'h1FFFF) begin
                w_scale_nxt = 17'h1FFFF;
                w_sat_hit   = 1'b1;
            end else begin
                w_scale_nxt = w_scale_up[16:0];
            end
        end
        // Positive gt-lt imbalance pulls the offset down.
        if (w_d > w_db) begin
            if (r_offset <= -8'sd127) begin
                w_offset_nxt = -8'sd128;
                w_sat_hit    = 1'b1;
            end else begin
                w_offset_nxt = r_offset - 8'sd1;
            end
        end else if (w_d < -w_db) begin
            if (r_offset >= 8'sd126) begin
                w_offset_nxt = 8'sd127;
                w_sat_hit    = 1'b1;
            end else begin
                w_offset_nxt = r_offset + 8'sd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_oneshot_mode <= 1'b0;
            r_enable_d     <= 1'b0;
            r_oneshot_d    <= 1'b0;
            r_sq           <= '0;
            r_gt           <= '0;
            r_lt           <= '0;
            r_scale        <= SCALE_INIT;
            r_offset       <= '0;
            r_sat          <= 1'b0;
            r_iter         <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_enable_d  <= enable_i;
            r_oneshot_d <= oneshot_i;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) r_sat <= 1'b0;
                    if (w_start) begin
                        r_oneshot_mode <= !enable_i;
                        r_scale        <= SCALE_INIT;
                    end
                end
                S_TICK:   r_cnt <= '0;
                S_INTEG:  r_cnt <= w_win_end ? 20'd0 : r_cnt + 20'd1;
                S_SETTLE: r_cnt <= r_cnt + 20'd1;
                S_CAPTURE: begin
                    r_sq <= agc.sq_accum_i;
                    r_gt <= agc.gt_accum_i;
                    r_lt <= agc.lt_accum_i;
                end
                S_COMPUTE: begin
                    r_scale  <= w_scale_nxt;
                    r_offset <= w_offset_nxt;
                    if (w_sat_hit) r_sat <= 1'b1;
                end
                S_APPLY:  r_iter <= r_iter + 16'd1;
                default:  ;
            endcase
        end
    end

`ifdef AGC_LOOP_CTRL_STATS_EN
    logic [23:0] r_last_sq;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_sq <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_last_sq <= agc.sq_accum_i;
        end
    end
    assign last_sq_o = r_last_sq;
`else
    assign last_sq_o = 24'd0;
`endif

    assign agc.agc_rst_o       = w_rst;
    assign agc.agc_tick_o      = w_tick;
    assign agc.agc_ce_o        = w_ce;
    assign agc.agc_scale_o     = r_scale;
    assign agc.agc_offset_o    = r_offset;
    assign agc.agc_scale_ce_o  = w_load;
    assign agc.agc_offset_ce_o = w_load;
    assign agc.agc_apply_o     = w_apply;
    assign busy_o              = (r_state != S_IDLE);
    assign cycle_done_o        = w_apply;
    assign sat_o               = r_sat;
    assign iter_count_o        = r_iter;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed + randomized bench for agc_loop_ctrl against an integer reference model of the loop rules.
module tb_agc_loop_ctrl;
    localparam int          W     = 16;
    localparam int          S     = 6;
    localparam int          SH    = 4;
    localparam logic [16:0] SINIT = 17'h04000;
    localparam int          LAT   = 2 + W + S + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        oneshot;
    logic [23:0] target;
    logic [23:0] sdb;
    logic [20:0] odb;
    logic        busy;
    logic        cdone;
    logic        sat;
    logic [15:0] iter;
    logic [23:0] last_sq;

    agc_loop_ctrl_if agc_if ();

    agc_loop_ctrl #(
        .WINDOW_CLOCKS(W),
        .SETTLE_CLOCKS(S),
        .SCALE_SHIFT(SH),
        .SCALE_INIT(SINIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .oneshot_i(oneshot),
        .target_sq_i(target),
        .sq_dband_i(sdb),
        .ofs_dband_i(odb),
        .agc(agc_if),
        .busy_o(busy),
        .cycle_done_o(cdone),
        .sat_o(sat),
        .iter_count_o(iter),
        .last_sq_o(last_sq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_scale;
    int m_ofs;
    int m_sat;
    int m_iter;
    int m_last;

    // per-cycle observations
    int          o_lat;
    int          o_ce;
    int          o_load_at;
    int          o_apply_at;
    int          o_pair_bad;
    logic        o_cd;
    logic [16:0] o_scale;
    logic [7:0]  o_ofs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start(input bit rise);
        m_scale = SINIT;
        if (rise) m_sat = 0;
    endtask

    function automatic void model_cycle(input int sq, input int tgt, input int db,
                                        input int gt, input int lt, input int ob);
        int hi, lo, step, ns, no, d;
        hi = tgt + db;
        if (hi > 16777215) hi = 16777215;
        lo = tgt - db;
        if (lo < 0) lo = 0;
        step = m_scale / (1 << SH);
        if (step < 1) step = 1;
        if (sq > hi) begin
            ns = m_scale - step;
            if (ns <= 1) begin ns = 1; m_sat = 1; end
            m_scale = ns;
        end else if (sq < lo) begin
            ns = m_scale + step;
            if (ns >= 131071) begin ns = 131071; m_sat = 1; end
            m_scale = ns;
        end
        d = gt - lt;
        if (d > ob) begin
            no = m_ofs - 1;
            if (no <= -128) begin no = -128; m_sat = 1; end
            m_ofs = no;
        end else if (d < -ob) begin
            no = m_ofs + 1;
            if (no >= 127) begin no = 127; m_sat = 1; end
            m_ofs = no;
        end
        m_iter = (m_iter + 1) % 65536;
        m_last = sq;
    endfunction

    // Runs the bench through one cycle until apply is seen (bounded), recording what the core saw.
    task automatic observe(input int drop_at, input int os_at);
        o_lat = 0; o_ce = 0; o_load_at = -1; o_apply_at = -1; o_pair_bad = 0;
        o_cd = 1'b0; o_scale = 'x; o_ofs = 'x;
        while (o_apply_at < 0 && o_lat < 200) begin
            tick();
            o_lat++;
            if (o_lat == 1) oneshot = 1'b0;
            if (o_lat == drop_at) enable = 1'b0;
            if (os_at > 0 && o_lat == os_at) oneshot = 1'b1;
            if (os_at > 0 && o_lat == os_at + 1) oneshot = 1'b0;
            if (agc_if.agc_ce_o === 1'b1) o_ce++;
            if (agc_if.agc_scale_ce_o !== agc_if.agc_offset_ce_o) o_pair_bad++;
            if (agc_if.agc_scale_ce_o === 1'b1) begin
                o_load_at = o_lat;
                o_scale   = agc_if.agc_scale_o;
                o_ofs     = agc_if.agc_offset_o;
            end
            if (agc_if.agc_apply_o === 1'b1) begin
                o_apply_at = o_lat;
                o_cd       = cdone;
            end
        end
    endtask

    task automatic check_cycle(input string tag);
        chk({tag, " apply_latency"}, o_apply_at, LAT);
        chk({tag, " load_latency"}, o_load_at, LAT - 1);
        chk({tag, " ce_clocks"}, o_ce, W);
        chk({tag, " ce_pair"}, o_pair_bad, 0);
        chk({tag, " cycle_done"}, o_cd, 1);
        chk({tag, " scale"}, o_scale, m_scale);
        chk({tag, " offset"}, $signed(o_ofs), m_ofs);
        chk({tag, " sat"}, sat, m_sat);
`ifdef AGC_LOOP_CTRL_STATS_EN
        chk({tag, " last_sq"}, last_sq, m_last);
`else
        chk({tag, " last_sq"}, last_sq, 0);
`endif
    endtask

    task automatic set_core(input int sq, input int gt, input int lt);
        agc_if.sq_accum_i = 24'(sq);
        agc_if.gt_accum_i = 21'(gt);
        agc_if.lt_accum_i = 21'(lt);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " scale"}, agc_if.agc_scale_o, SINIT);
        chk({tag, " offset"}, agc_if.agc_offset_o, 0);
        chk({tag, " iter"}, iter, 0);
        chk({tag, " sat"}, sat, 0);
        chk({tag, " pulses"}, {agc_if.agc_rst_o, agc_if.agc_tick_o, agc_if.agc_ce_o,
            agc_if.agc_scale_ce_o, agc_if.agc_offset_ce_o, agc_if.agc_apply_o, cdone}, 0);
        chk({tag, " last_sq"}, last_sq, 0);
    endtask

    initial begin
        int sq, gt, lt, tg, db, ob, cnt_ap, cnt_busy;

        rst = 1'b1; enable = 1'b0; oneshot = 1'b0;
        target = '0; sdb = '0; odb = '0;
        set_core(0, 0, 0);
        m_scale = SINIT; m_ofs = 0; m_sat = 0; m_iter = 0; m_last = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_values("reset");

        // oneshot, sq inside deadband: scale unchanged, single cycle
        target = 24'd1000; sdb = 24'd10; odb = 21'd0;
        sq = 1000; gt = 0; lt = 0;
        set_core(sq, gt, lt);
        oneshot = 1'b1;
        model_start(1);
        observe(0, 0);
        model_cycle(sq, 1000, 10, gt, lt, 0);
        check_cycle("t1");
        chk("t1 scale_const", o_scale, 17'h04000);
        tick();
        chk("t1 iter", iter, m_iter);
        chk("t1 idle", busy, 0);

        // sq above window: one downward step of 1/16
        sq = 5000;
        set_core(sq, gt, lt);
        oneshot = 1'b1;
        model_start(1);
        observe(0, 0);
        model_cycle(sq, 1000, 10, gt, lt, 0);
        check_cycle("t2");
        chk("t2 scale_const", o_scale, 17'h03C00);
        tick();
        chk("t2 idle", busy, 0);

        // continuous run with sq well below target: scale climbs to cap and holds
        target = 24'd100; db = $urandom_range(0, 50); sdb = 24'(db);
        ob = 20; odb = 21'(ob);
        enable = 1'b1;
        model_start(1);
        for (int i = 0; i < 42; i++) begin
            sq = $urandom_range(0, 49);
            lt = $urandom_range(100, 1000);
            gt = lt + $urandom_range(0, 40) - 20;
            set_core(sq, gt, lt);
            observe((i == 41) ? 21 : 0, 0);
            model_cycle(sq, 100, db, gt, lt, ob);
            check_cycle("t3");
        end
        chk("t3 scale_cap", agc_if.agc_scale_o, 17'h1FFFF);
        chk("t3 sat_set", sat, 1);
        tick();
        chk("t3 idle", busy, 0);
        chk("t3 iter", iter, m_iter);

        // offset walks down to -128 and holds; fresh enable edge clears sat
        tg = $urandom_range(1000, 100000); target = 24'(tg);
        db = $urandom_range(0, 100); sdb = 24'(db);
        ob = 50; odb = 21'(ob);
        set_core(tg, 200, 0);
        enable = 1'b1;
        model_start(1);
        for (int i = 0; i < 132; i++) begin
            observe((i == 131) ? 21 : 0, 0);
            model_cycle(tg, tg, db, 200, 0, ob);
            check_cycle("t4");
        end
        chk("t4 offset_floor", $signed(agc_if.agc_offset_o), -128);
        chk("t4 sat_set", sat, 1);
        tick();
        chk("t4 idle", busy, 0);

        // reset during INTEG aborts with no load/apply
        oneshot = 1'b1;
        tick();
        oneshot = 1'b0;
        repeat (8) tick();
        chk("t5 in_integ", agc_if.agc_ce_o, 1);
        rst = 1'b1;
        tick();
        check_reset_values("t5 rst");
        rst = 1'b0;
        m_scale = SINIT; m_ofs = 0; m_sat = 0; m_iter = 0; m_last = 0;
        cnt_ap = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (agc_if.agc_scale_ce_o === 1'b1 || agc_if.agc_offset_ce_o === 1'b1 ||
                agc_if.agc_apply_o === 1'b1 || busy === 1'b1) cnt_ap++;
        end
        chk("t5 no_activity", cnt_ap, 0);

        // enable dropped in SETTLE, oneshot while busy ignored, random operands
        for (int k = 0; k < 6; k++) begin
            sq = $urandom_range(0, 24'hFFFFFF);
            tg = (k == 0) ? 24'hFFFFF0 : $urandom_range(0, 24'hFFFFFF);
            db = (k == 1) ? tg + 5 : $urandom_range(0, 24'h0FFFFF);
            if (db > 24'hFFFFFF) db = 24'hFFFFFF;
            gt = $urandom_range(0, 21'h1FFFFF);
            lt = $urandom_range(0, 21'h1FFFFF);
            ob = $urandom_range(0, 21'h0FFFFF);
            target = 24'(tg); sdb = 24'(db); odb = 21'(ob);
            set_core(sq, gt, lt);
            if (k % 2 == 0) begin
                enable = 1'b1;
                model_start(1);
                observe(21, 10);
            end else begin
                oneshot = 1'b1;
                model_start(1);
                observe(0, 12);
            end
            model_cycle(sq, tg, db, gt, lt, ob);
            check_cycle("t6");
            cnt_ap = 0; cnt_busy = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (agc_if.agc_apply_o === 1'b1) cnt_ap++;
                if (busy === 1'b1) cnt_busy++;
            end
            chk("t6 no_extra_apply", cnt_ap, 0);
            chk("t6 busy_low", cnt_busy, 0);
            chk("t6 iter", iter, m_iter);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
